// File: rtl/omux_arbiter.sv
// omux_arbiter: round-robin scheduler sharing one outbound byte stream among
// up to 16 output-mux sources, forwarding bounded bursts per grant.
// Optional feature macro OMUX_ARB_HEADER_EN: when defined, each burst is
// prefixed with a one-byte source header {4'hC, id}.
module omux_arbiter #(
    parameter int unsigned N_SRC     = 2,
    parameter int unsigned BURST_LEN = 64
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic [N_SRC-1:0]     src_req_i,
    input  logic [8*N_SRC-1:0]   src_data_i,
    input  logic [N_SRC-1:0]     src_mask_i,
    output logic [N_SRC-1:0]     src_sel_o,
    output logic [N_SRC-1:0]     src_ack_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic                 busy_o,
    output logic [3:0]           grant_id_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef OMUX_ARB_HEADER_EN
        S_HEADER = 2'd1,
`endif
        S_DATA   = 2'd2
    } state_e;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);
    localparam logic [3:0] LAST_SRC  = 4'(N_SRC - 1);

    state_e           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [7:0]       cnt_q, cnt_d;
`ifdef OMUX_ARB_HEADER_EN
    logic [7:0]       hdr_q, hdr_d;
`endif

    logic [N_SRC-1:0] eff_req;
    logic             win_found;
    logic [3:0]       win_id;
    logic             gnt_req;
    logic [7:0]       gnt_data;
    logic [N_SRC-1:0] gnt_onehot;
    logic [3:0]       next_ptr;

    assign eff_req  = src_req_i & src_mask_i;
    assign next_ptr = (gnt_q >= LAST_SRC) ? 4'd0 : gnt_q + 4'd1;

    // Decode the registered grant into its effective request, byte lane and one-hot select
    always_comb begin
        gnt_req    = 1'b0;
        gnt_data   = '0;
        gnt_onehot = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (gnt_q == 4'(k)) begin
                gnt_req       = eff_req[k];
                gnt_data      = src_data_i[8*k +: 8];
                gnt_onehot[k] = 1'b1;
            end
        end
    end

    // Cyclic search from ptr: first pass covers [ptr, N_SRC), second pass wraps to [0, ptr)
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (!win_found && eff_req[j] && (4'(j) >= ptr_q)) begin
                win_found = 1'b1;
                win_id    = 4'(j);
            end
        end
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (!win_found && eff_req[j]) begin
                win_found = 1'b1;
                win_id    = 4'(j);
            end
        end
    end

    // Next-state and output decode for the IDLE / HEADER / DATA sequencer
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
`ifdef OMUX_ARB_HEADER_EN
        hdr_d      = hdr_q;
`endif
        src_sel_o  = '0;
        src_ack_o  = '0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        busy_o     = 1'b0;
        grant_id_o = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    gnt_d = win_id;
`ifdef OMUX_ARB_HEADER_EN
                    hdr_d   = {4'hC, win_id};
                    state_d = S_HEADER;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef OMUX_ARB_HEADER_EN
            S_HEADER: begin
                busy_o     = 1'b1;
                src_sel_o  = gnt_onehot;
                grant_id_o = gnt_q;
                tx_valid_o = 1'b1;
                tx_data_o  = hdr_q;
                if (tx_ready_i) begin
                    state_d = S_DATA;
                end
            end
`endif
            S_DATA: begin
                busy_o     = 1'b1;
                src_sel_o  = gnt_onehot;
                grant_id_o = gnt_q;
                tx_valid_o = gnt_req;
                tx_data_o  = gnt_data;
                if (!gnt_req) begin
                    state_d = S_IDLE;
                    ptr_d   = next_ptr;
                end else if (tx_ready_i) begin
                    src_ack_o = gnt_onehot;
                    cnt_d     = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == BURST_MAX) begin
                        state_d = S_IDLE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pointer, grant and counter registers with asynchronous clear
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
`ifdef OMUX_ARB_HEADER_EN
            hdr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
`ifdef OMUX_ARB_HEADER_EN
            hdr_q   <= hdr_d;
`endif
        end
    end

endmodule

// File: doc/omux_arbiter.md
# omux_arbiter

Round-robin scheduler that shares the host interface's single outbound byte stream between up to 16 output-mux sources, such as record buffers. Each source raises a request while it holds a byte. The arbiter grants one source at a time and forwards a bounded burst of its bytes toward the host TX path, optionally prefixed by a one-byte source header. It sits between the `omux_*` sources and the host interface's transmit side.

## Interface

Parameters:
- `N_SRC`, default 2: number of sources, 1..16.
- `BURST_LEN`, default 64: maximum data bytes per grant, 1..255.

Ports:
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `nreset_i`  in  1  asynchronous, active-low reset.
- `src_req_i`  in  N_SRC  source k has a valid byte on its data lane.
- `src_data_i`  in  8*N_SRC  source k's byte on bits [8k+7:8k].
- `src_mask_i`  in  N_SRC  1 enables source k; 0 makes it treated as not requesting.
- `src_sel_o`  out  N_SRC  one-hot select of the granted source; all zero when idle.
- `src_ack_o`  out  N_SRC  one-cycle pulse: the granted source's current byte was consumed, so advance.
- `tx_valid_o`  out  1  `tx_data_o` is valid.
- `tx_data_o`  out  8  outbound byte.
- `tx_ready_i`  in  1  host side accepts the byte this cycle.
- `busy_o`  out  1  a grant is active (state is not IDLE).
- `grant_id_o`  out  4  index of the granted source; 0 when idle.

## Operation

- A transfer occurs in any cycle where `tx_valid_o` and `tx_ready_i` are both high.
- Effective request for source k is `src_req_i[k] & src_mask_i[k]`.
- Round-robin pointer `ptr`:
  - Reset value 0.
  - After a burst from source g ends, `ptr` becomes (g+1) mod `N_SRC`.
  - In IDLE, the first effective requester at or after `ptr` (cyclic) wins.

States:
- **IDLE**
  - No effective requests: stay in IDLE.
  - Otherwise register the winner and go to HEADER, or to DATA if the header is compiled out.
  - Burst counter cleared.
- **HEADER**
  - `tx_valid_o`=1, `tx_data_o`={4'hC, grant_id[3:0]}.
  - On transfer go to DATA.
  - `src_ack_o` stays 0; the header never consumes source data.
- **DATA**
  - `tx_valid_o` = effective request of the granted source.
  - `tx_data_o` = granted source's lane.
  - On each transfer: pulse `src_ack_o[g]`, increment the burst counter.
  - Exit to IDLE in either of these cases:
    - The transfer that makes count == `BURST_LEN`.
    - Any cycle in which the granted source's effective request is low.

Rules:
- `src_sel_o` and `grant_id_o` hold the grant through HEADER and DATA, and drop in IDLE.
- Masking a source mid-burst ends that burst at the next cycle its effective request evaluates low. The header already sent is not retracted.
- A request dropping while the header is pending has no effect on HEADER; the burst then ends with zero data bytes.
- Burst counter is 8 bits and never wraps; `BURST_LEN` bounds it.
- Reset, asynchronous at any time:
  - State goes to IDLE, `ptr` to 0, counter to 0.
  - Every output goes to 0: `src_sel_o`, `src_ack_o`, `tx_valid_o`, `tx_data_o`, `busy_o`, `grant_id_o`.
  - A partially sent burst is abandoned; no `src_ack_o` is issued for it.

## Timing

- Request at cycle n in IDLE → grant registered at edge n+1 → header valid in cycle n+1.
- Header transferred in cycle m → first data byte valid in cycle m+1, provided the source requests.
- DATA, `tx_ready_i`=1, source always requesting: one byte per cycle.
- `src_ack_o` is asserted combinationally in the transfer cycle. The source must present its next byte, or drop its request, by the following cycle.
- At least one IDLE cycle separates consecutive bursts. Arbitration happens only in IDLE.
- Backpressure (`tx_ready_i`=0): `tx_valid_o`, `tx_data_o`, `src_sel_o` and the counter hold, and no ack is issued. Data stability relies on the source holding its lane while it is unacked.
- `tx_data_o` in HEADER comes from a register. In DATA it is a combinational mux of `src_data_i`.

## Configuration

- `OMUX_ARB_HEADER_EN` defined: HEADER state present; every burst is prefixed by {4'hC, id}.
- Not defined:
  - HEADER state removed; IDLE goes directly to DATA.
  - The stream contains only source bytes.
  - Grant-to-first-byte latency is unchanged (1 cycle).

## Test plan

- **Single source (macro on, `tx_ready_i`=1):** source 0 offers 0x11, 0x22, 0x33 then drops `src_req_i[0]` → stream C0 11 22 33; `src_ack_o[0]` pulses 3 times; `busy_o` returns to 0.
- **Round robin:** `N_SRC`=2, `BURST_LEN`=4, both sources requesting continuously → C0 + 4 src0 bytes, C1 + 4 src1 bytes, repeating, with one idle cycle between bursts.
- **Backpressure:** `tx_ready_i` low for 5 cycles after the 2nd data byte → `tx_data_o` stable, no `src_ack_o`; the burst resumes with byte 3 and totals `BURST_LEN` bytes.
- **Masking:** `src_mask_i`=2'b01 with both requesting → only C0 bursts; setting the mask to 2'b11 → C1 bursts interleave starting with the next arbitration.
- **Reset mid-burst:** `nreset_i` low during DATA of source 1 → all outputs 0 immediately; after release, first grant goes to source 0.
- **Macro off:** rerun the single-source scenario → stream is 11 22 33 with first byte valid one cycle after the request.
